// File: rtl/alu_seq_if.sv
// Command and result handshake bundle for the alu_seq sequencing stage.
// Valid/ready rule for both channels: a beat transfers on a rising clk edge
// where valid and ready are both 1; the producer holds its payload while
// valid is high and ready is low.
interface alu_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       cmd_use_acc;
   logic       cmd_clr;
   logic       res_valid;
   logic       res_ready;
   logic [4:0] res_data;
   logic       res_zero;

   // Stimulus / upstream + downstream side.
   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_clr, res_ready,
      input  cmd_ready, res_valid, res_data, res_zero
   );

   // Sequencer side.
   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_clr, res_ready,
      output cmd_ready, res_valid, res_data, res_zero
   );
endinterface

// File: rtl/alu_seq.sv
// Sequencing and result-capture stage around a 4-bit combinational ALU.
// Commands latch operands/selects into registers feeding the ALU, the ALU
// result is captured one cycle later, and held for a downstream handshake.
// An accumulator allows chaining; op_count counts completed operations.
module alu_seq (
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_if.slave   bus,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       alu_s0,
   output logic       alu_s1,
   output logic       alu_s3,
   input  logic [4:0] alu_out,
   output logic [3:0] acc,
   output logic [7:0] op_count,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       cmd_xfer;
   logic       latch_cmd;
   logic       clr_acc;
   logic [4:0] res_data_q;
   logic       res_zero_q;

   // Command is taken in IDLE, or in DONE only when the result leaves on the
   // same edge, so a new command never overwrites an unconsumed result.
   assign bus.cmd_ready = (state == IDLE) || ((state == DONE) && bus.res_ready);
   assign bus.res_valid = (state == DONE);
   assign bus.res_data  = res_data_q;
   assign bus.res_zero  = res_zero_q;
   assign dbg_state     = state;

   assign cmd_xfer  = bus.cmd_valid && bus.cmd_ready;
   assign latch_cmd = cmd_xfer && !bus.cmd_clr;
   assign clr_acc   = cmd_xfer && bus.cmd_clr;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a clear command never leaves IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (latch_cmd) state_nxt = EXEC;
         EXEC: state_nxt = DONE;
         DONE: begin
            // cmd_ready in DONE implies res_ready, so any command transfer
            // here coincides with the result transfer.
            if (bus.res_ready) state_nxt = latch_cmd ? EXEC : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ALU operand/select registers, loaded only when a command latches.
   // In DONE the accumulator already holds the result of the preceding EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a  <= 4'd0;
         alu_b  <= 4'd0;
         alu_s0 <= 1'b0;
         alu_s1 <= 1'b0;
         alu_s3 <= 1'b0;
      end else if (latch_cmd) begin
         alu_a  <= bus.cmd_use_acc ? acc : bus.cmd_a;
         alu_b  <= bus.cmd_b;
         alu_s3 <= bus.cmd_op[2];
         alu_s0 <= bus.cmd_op[1];
         alu_s1 <= bus.cmd_op[0];
      end
   end

   // Result capture, accumulator and operation counter.
   // alu_out is only looked at on the edge that closes EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data_q <= 5'd0;
         res_zero_q <= 1'b0;
         acc        <= 4'd0;
         op_count   <= 8'd0;
      end else begin
         if (state == EXEC) begin
            res_data_q <= alu_out;
            res_zero_q <= (alu_out[3:0] == 4'd0);
            acc        <= alu_out[3:0];
            op_count   <= op_count + 8'd1;
         end else if (clr_acc) begin
            acc <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq, with a behavioural model of the 4-bit ALU.
module tb_alu_seq;

   logic       clk;
   logic       rst_n;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic       alu_s0;
   logic       alu_s1;
   logic       alu_s3;
   logic [4:0] alu_out;
   logic [3:0] acc;
   logic [7:0] op_count;
   logic [1:0] dbg_state;

   int         errors;
   int         checks;
   logic [7:0] cnt;

   alu_seq_if bus ();

   alu_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_s0    (alu_s0),
      .alu_s1    (alu_s1),
      .alu_s3    (alu_s3),
      .alu_out   (alu_out),
      .acc       (acc),
      .op_count  (op_count),
      .dbg_state (dbg_state)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External 4-bit ALU model.
   always_comb begin
      alu_out = 5'd0;
      case ({alu_s3, alu_s0, alu_s1})
         3'b000: alu_out = {1'b0, alu_a} + {1'b0, alu_b};
         3'b001: alu_out = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
         3'b010: alu_out = {1'b0, alu_a} + 5'd1;
         3'b011: alu_out = {1'b0, alu_a} + 5'd15;
         3'b100: alu_out = {1'b0, alu_a & alu_b};
         3'b101: alu_out = {1'b0, alu_a | alu_b};
         3'b110: alu_out = {1'b0, alu_a ^ alu_b};
         default: alu_out = {2'b00, alu_a[3:1]};
      endcase
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Drive one command for exactly one edge; caller guarantees cmd_ready.
   task automatic send_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic use_acc, input logic clr);
      bus.cmd_op      = op;
      bus.cmd_a       = a;
      bus.cmd_b       = b;
      bus.cmd_use_acc = use_acc;
      bus.cmd_clr     = clr;
      bus.cmd_valid   = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_clr     = 1'b0;
   endtask

   // Full operation from IDLE: command, EXEC, observe DONE, pop result.
   task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic use_acc, output logic v, output logic [4:0] d,
                        output logic z, output logic [3:0] ac);
      send_cmd(op, a, b, use_acc, 1'b0);
      @(posedge clk); #1;
      v  = bus.res_valid;
      d  = bus.res_data;
      z  = bus.res_zero;
      ac = acc;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      cnt = cnt + 8'd1;
   endtask

   task automatic test_reset;
      logic [29:0] all_out;
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_a = 4'd0; bus.cmd_b = 4'd0;
      bus.cmd_use_acc = 1'b0; bus.cmd_clr = 1'b0; bus.res_ready = 1'b0;
      cnt = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      all_out = {alu_a, alu_b, alu_s0, alu_s1, alu_s3, bus.res_data, bus.res_zero,
                 bus.res_valid, acc, op_count};
      checks++; if (all_out !== 30'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      // Reach DONE, then reset asynchronously mid-cycle.
      send_cmd(3'b000, 4'd1, 4'd1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++; if (dbg_state !== 2'd2 || op_count !== 8'd1) begin errors++; $display("FAIL reset_pre_done: got state=%0d cnt=%0d expected 2/1", dbg_state, op_count); end
      rst_n = 1'b0;
      #1;
      all_out = {alu_a, alu_b, alu_s0, alu_s1, alu_s3, bus.res_data, bus.res_zero,
                 bus.res_valid, acc, op_count};
      checks++; if (all_out !== 30'd0) begin errors++; $display("FAIL reset_mid_done: got %h expected 0", all_out); end
      checks++; if (bus.cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL reset_mid_done_idle: got rdy=%b state=%0d expected 1/0", bus.cmd_ready, dbg_state); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // Reset during EXEC discards the operation.
      send_cmd(3'b010, 4'd5, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.res_valid !== 1'b0 || op_count !== 8'd0 || dbg_state !== 2'd0) begin errors++; $display("FAIL reset_mid_exec: got v=%b cnt=%0d state=%0d expected 0/0/0", bus.res_valid, op_count, dbg_state); end
   endtask

   task automatic test_add;
      send_cmd(3'b000, 4'b1011, 4'b1111, 1'b0, 1'b0);
      checks++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL add_exec: got v=%b rdy=%b expected 0/0", bus.res_valid, bus.cmd_ready); end
      checks++; if ({alu_a, alu_b, alu_s3, alu_s0, alu_s1} !== 11'b1011_1111_000) begin errors++; $display("FAIL add_alu_regs: got %b expected 10111111000", {alu_a, alu_b, alu_s3, alu_s0, alu_s1}); end
      @(posedge clk); #1;
      checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 5'b11010) begin errors++; $display("FAIL add_result: got v=%b d=%b expected 1/11010", bus.res_valid, bus.res_data); end
      checks++; if (acc !== 4'b1010 || bus.res_zero !== 1'b0) begin errors++; $display("FAIL add_acc_zero: got acc=%b z=%b expected 1010/0", acc, bus.res_zero); end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      cnt = cnt + 8'd1;
      checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== 5'b11010) begin errors++; $display("FAIL add_after_pop: got v=%b d=%b expected 0/11010", bus.res_valid, bus.res_data); end
      checks++; if (op_count !== cnt) begin errors++; $display("FAIL add_count: got %0d expected %0d", op_count, cnt); end
   endtask

   task automatic test_sub;
      logic v, z; logic [4:0] d; logic [3:0] ac;
      do_op(3'b001, 4'd5, 4'd3, 1'b0, v, d, z, ac);
      checks++; if (v !== 1'b1 || d !== 5'b10010) begin errors++; $display("FAIL sub_5_3: got v=%b d=%b expected 1/10010", v, d); end
      do_op(3'b001, 4'd3, 4'd5, 1'b0, v, d, z, ac);
      checks++; if (v !== 1'b1 || d !== 5'b01110 || ac !== 4'b1110) begin errors++; $display("FAIL sub_3_5: got v=%b d=%b acc=%b expected 1/01110/1110", v, d, ac); end
   endtask

   task automatic test_dec_zero;
      logic v, z; logic [4:0] d; logic [3:0] ac;
      do_op(3'b011, 4'd0, 4'd9, 1'b0, v, d, z, ac);
      checks++; if (d !== 5'b01111 || z !== 1'b0) begin errors++; $display("FAIL dec_0: got d=%b z=%b expected 01111/0", d, z); end
      do_op(3'b010, 4'b1111, 4'd0, 1'b0, v, d, z, ac);
      checks++; if (d !== 5'b10000 || z !== 1'b1 || ac !== 4'd0) begin errors++; $display("FAIL inc_15: got d=%b z=%b acc=%b expected 10000/1/0000", d, z, ac); end
   endtask

   task automatic test_chain;
      logic v, z; logic [4:0] d; logic [3:0] ac;
      logic [7:0] base;
      // Load acc with something non-zero, then clear it.
      do_op(3'b000, 4'd6, 4'd1, 1'b0, v, d, z, ac);
      send_cmd(3'b000, 4'd9, 4'd9, 1'b0, 1'b1);
      checks++; if (acc !== 4'd0 || dbg_state !== 2'd0 || op_count !== cnt) begin errors++; $display("FAIL chain_clr: got acc=%0d state=%0d cnt=%0d expected 0/0/%0d", acc, dbg_state, op_count, cnt); end
      base = cnt;
      bus.cmd_op = 3'b010; bus.cmd_a = 4'd0; bus.cmd_b = 4'd0;
      bus.cmd_use_acc = 1'b1; bus.cmd_clr = 1'b0;
      bus.res_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (dbg_state !== 2'd1 || bus.res_valid !== 1'b0 || alu_a !== 4'(i)) begin errors++; $display("FAIL chain_exec%0d: got state=%0d v=%b a=%0d expected 1/0/%0d", i, dbg_state, bus.res_valid, alu_a, i); end
         if (i == 2) bus.cmd_valid = 1'b0;
         @(posedge clk); #1;
         checks++; if (bus.res_valid !== 1'b1 || acc !== 4'(i + 1) || bus.res_data !== 5'(i + 1)) begin errors++; $display("FAIL chain_done%0d: got v=%b acc=%0d d=%0d expected 1/%0d/%0d", i, bus.res_valid, acc, bus.res_data, i + 1, i + 1); end
         cnt = cnt + 8'd1;
      end
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.cmd_use_acc = 1'b0;
      checks++; if (op_count !== base + 8'd3 || dbg_state !== 2'd0) begin errors++; $display("FAIL chain_count: got cnt=%0d state=%0d expected %0d/0", op_count, dbg_state, base + 8'd3); end
      do_op(3'b111, 4'd0, 4'd0, 1'b1, v, d, z, ac);
      checks++; if (d !== 5'b00001 || ac !== 4'd1) begin errors++; $display("FAIL chain_shr: got d=%b acc=%0d expected 00001/1", d, ac); end
   endtask

   task automatic test_backpressure;
      send_cmd(3'b110, 4'b1100, 4'b1010, 1'b0, 1'b0);
      @(posedge clk); #1;
      cnt = cnt + 8'd1;
      // Pending command waits behind the unconsumed result.
      bus.cmd_op = 3'b000; bus.cmd_a = 4'b0010; bus.cmd_b = 4'b0011;
      bus.cmd_use_acc = 1'b0; bus.cmd_clr = 1'b0; bus.cmd_valid = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 5'b00110 || bus.cmd_ready !== 1'b0 || op_count !== cnt) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%b rdy=%b cnt=%0d expected 1/00110/0/%0d", i, bus.res_valid, bus.res_data, bus.cmd_ready, op_count, cnt); end
         @(posedge clk); #1;
      end
      bus.res_ready = 1'b1;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b expected 1", bus.cmd_ready); end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      checks++; if (dbg_state !== 2'd1 || bus.res_valid !== 1'b0 || alu_a !== 4'b0010 || alu_b !== 4'b0011) begin errors++; $display("FAIL bp_accept: got state=%0d v=%b a=%b b=%b expected 1/0/0010/0011", dbg_state, bus.res_valid, alu_a, alu_b); end
      @(posedge clk); #1;
      cnt = cnt + 8'd1;
      checks++; if (bus.res_data !== 5'b00101 || acc !== 4'b0101) begin errors++; $display("FAIL bp_second: got d=%b acc=%b expected 00101/0101", bus.res_data, acc); end
      // Result transfer together with a clear command.
      bus.cmd_clr = 1'b1; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; bus.cmd_clr = 1'b0; bus.res_ready = 1'b0;
      checks++; if (acc !== 4'd0 || dbg_state !== 2'd0 || op_count !== cnt) begin errors++; $display("FAIL bp_done_clr: got acc=%0d state=%0d cnt=%0d expected 0/0/%0d", acc, dbg_state, op_count, cnt); end
   endtask

   task automatic test_wrap;
      logic v, z; logic [4:0] d; logic [3:0] ac;
      int n;
      n = 256 - int'(cnt);
      for (int i = 0; i < n; i++) begin
         do_op(3'b000, 4'(i), 4'd1, 1'b0, v, d, z, ac);
         if (i == n - 2) begin
            checks++; if (op_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", op_count); end
         end
      end
      checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", op_count); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_add();
      test_sub();
      test_dec_zero();
      test_chain();
      test_backpressure();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
